// File: rtl/orion_csr_counters_pkg.sv
// Shared CSR addresses, access-op encodings and event indices for the Orion counter block.
package orion_csr_counters_pkg;

  typedef logic [11:0] csr_addr_t;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_ops_t;

  localparam csr_addr_t CSR_MCYCLE        = 12'hB00;
  localparam csr_addr_t CSR_MINSTRET      = 12'hB02;
  localparam csr_addr_t CSR_MHPMCOUNTER3  = 12'hB03;
  localparam csr_addr_t CSR_MCYCLEH       = 12'hB80;
  localparam csr_addr_t CSR_MINSTRETH     = 12'hB82;
  localparam csr_addr_t CSR_MHPMCOUNTER3H = 12'hB83;
  localparam csr_addr_t CSR_CYCLE         = 12'hC00;
  localparam csr_addr_t CSR_HPMCOUNTER3   = 12'hC03;
  localparam csr_addr_t CSR_CYCLEH        = 12'hC80;
  localparam csr_addr_t CSR_HPMCOUNTER3H  = 12'hC83;
  localparam csr_addr_t CSR_MCOUNTINHIBIT = 12'h320;
  localparam csr_addr_t CSR_MHPMEVENT3    = 12'h323;
  localparam csr_addr_t CSR_SCOUNTOVF     = 12'hDA0;

  localparam int HPM_MAX = 29;

  typedef enum logic [7:0] {
    EV_LOAD         = 8'd0,
    EV_STORE        = 8'd1,
    EV_BRANCH_TAKEN = 8'd2,
    EV_STALL        = 8'd3
  } hpm_event_t;

  // Counter slot 0 is mcycle, slot 1 is minstret, slot k>=2 is mhpmcounter(k+1).
  function automatic logic [4:0] slot_to_index(input int slot);
    if (slot == 0) return 5'd0;
    else if (slot == 1) return 5'd2;
    else return 5'(slot + 1);
  endfunction

endpackage

// File: rtl/orion_csr_counters_counter.sv
// One CNT_W-bit machine counter with half-word write and optional sticky overflow.
// ORION_HPM_OVF_EN adds the overflow bit output.
module orion_hpm_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] count
`ifdef ORION_HPM_OVF_EN
  ,
  output logic             ovf
`endif
);

  // A write in the same cycle suppresses the increment.
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (wr_lo) count[31:0] <= wdata;
    else if (wr_hi) count[CNT_W-1:32] <= wdata[CNT_W-33:0];
    else if (inc) count <= count + CNT_W'(1);
  end

`ifdef ORION_HPM_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else if (wr_lo || wr_hi) ovf <= 1'b0;
    else if (inc && (&count)) ovf <= 1'b1;
  end
`endif

endmodule

// File: rtl/orion_csr_counters.sv
// Machine counter/timer CSR block: cycle, instret, NUM_HPM perf counters, event selects, inhibit.
// ORION_HPM_OVF_EN enables per-HPM overflow bits, scountovf (DA0) and ovf_irq.
module orion_csr_counters
  import orion_csr_counters_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_HPM    = 4,
  parameter int NUM_EVENTS = 8,
  parameter int CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [11:0]           csr_addr,
  input  logic [XLEN-1:0]       csr_operand,
  input  logic [1:0]            csr_op,
  input  logic                  csr_ren,
  input  logic                  csr_wen,
  input  logic                  instr_retired,
  input  logic [NUM_EVENTS-1:0] hpm_event,
  output logic [XLEN-1:0]       csr_rdata,
  output logic                  csr_illegal,
  output logic                  ovf_irq
);

  localparam int NSLOT = NUM_HPM + 2;
  localparam int EVW   = $clog2(NUM_EVENTS + 1);
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

  logic [CNT_W-1:0] cnt [NSLOT];
  logic [NSLOT-1:0] cnt_inc, cnt_wr_lo, cnt_wr_hi;
  logic [EVW-1:0]   evt_sel [NUM_HPM];
  logic [31:0]      inhibit;
  logic [4:0]       idx;
  logic             is_mcnt, is_ucnt, is_hi, is_inh, is_evt, cnt_impl, legal, wr_ok;
  logic [63:0]      full;
  logic [31:0]      rd_val, wr_val, operand;

  assign idx     = csr_addr[4:0];
  assign operand = 32'(csr_operand);
  assign wr_ok   = csr_wen && legal;

`ifdef ORION_HPM_OVF_EN
  logic [NSLOT-1:0] cnt_ovf;
  logic [31:0]      scountovf;
  logic             is_ovf;

  assign is_ovf = (csr_addr == CSR_SCOUNTOVF);

  always_comb begin
    scountovf = '0;
    for (int s = 0; s < NSLOT; s++)
      scountovf[slot_to_index(s)] = (s >= 2) && cnt_ovf[s];
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_irq <= 1'b0;
    else ovf_irq <= |scountovf;
  end
`else
  assign ovf_irq = 1'b0;
`endif

  always_comb begin
    is_mcnt  = (csr_addr[11:8] == 4'hB) && (csr_addr[6:5] == 2'b00);
    is_ucnt  = (csr_addr[11:8] == 4'hC) && (csr_addr[6:5] == 2'b00);
    is_hi    = csr_addr[7];
    is_inh   = (csr_addr == CSR_MCOUNTINHIBIT);
    is_evt   = (csr_addr[11:5] == 7'h19) && (idx >= 5'd3) && (int'(idx) < 3 + NUM_HPM);
    cnt_impl = (idx == 5'd0) || (idx == 5'd2) || ((idx >= 5'd3) && (int'(idx) < 3 + NUM_HPM));
    legal    = (is_mcnt && cnt_impl) || (is_ucnt && cnt_impl && !csr_wen) || is_inh || is_evt;
`ifdef ORION_HPM_OVF_EN
    legal    = legal || (is_ovf && !csr_wen);
`endif
  end

  // Read value is always the pre-write, pre-increment state; RS/RC build on it.
  always_comb begin
    rd_val = '0;
    full   = '0;
    if (is_mcnt || is_ucnt) begin
      for (int s = 0; s < NSLOT; s++) begin
        if (slot_to_index(s) == idx) begin
          full   = 64'(cnt[s]);
          rd_val = is_hi ? full[63:32] : full[31:0];
        end
      end
    end
    if (is_inh) rd_val = inhibit;
    for (int h = 0; h < NUM_HPM; h++)
      if (is_evt && (int'(idx) == h + 3)) rd_val = 32'(evt_sel[h]);
`ifdef ORION_HPM_OVF_EN
    if (is_ovf) rd_val = scountovf;
`endif
    case (csr_op)
      CSR_OP_RW: wr_val = operand;
      CSR_OP_RS: wr_val = rd_val | operand;
      CSR_OP_RC: wr_val = rd_val & ~operand;
      default:   wr_val = rd_val;
    endcase
  end

  always_comb begin
    cnt_wr_lo = '0;
    cnt_wr_hi = '0;
    for (int s = 0; s < NSLOT; s++) begin
      if (wr_ok && is_mcnt && (slot_to_index(s) == idx)) begin
        cnt_wr_lo[s] = !is_hi;
        cnt_wr_hi[s] = is_hi;
      end
    end
  end

  always_comb begin
    cnt_inc    = '0;
    cnt_inc[0] = !inhibit[0];
    cnt_inc[1] = instr_retired && !inhibit[2];
    for (int h = 0; h < NUM_HPM; h++)
      for (int v = 1; v <= NUM_EVENTS; v++)
        if ((int'(evt_sel[h]) == v) && hpm_event[v-1] && !inhibit[h+3]) cnt_inc[h+2] = 1'b1;
  end

  for (genvar s = 0; s < NSLOT; s++) begin : g_cnt
    orion_hpm_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (cnt_inc[s]),
      .wr_lo (cnt_wr_lo[s]),
      .wr_hi (cnt_wr_hi[s]),
      .wdata (wr_val),
      .count (cnt[s])
`ifdef ORION_HPM_OVF_EN
      ,
      .ovf   (cnt_ovf[s])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inhibit     <= '0;
      csr_rdata   <= '0;
      csr_illegal <= 1'b0;
      for (int h = 0; h < NUM_HPM; h++) evt_sel[h] <= '0;
    end else begin
      if (csr_ren || csr_wen) begin
        csr_rdata   <= legal ? XLEN'(rd_val) : '0;
        csr_illegal <= !legal;
      end
      if (wr_ok && is_inh) inhibit <= wr_val & INH_MASK;
      // Out-of-range selector values collapse to "never count".
      for (int h = 0; h < NUM_HPM; h++)
        if (wr_ok && is_evt && (int'(idx) == h + 3))
          evt_sel[h] <= (wr_val > 32'(NUM_EVENTS)) ? '0 : wr_val[EVW-1:0];
    end
  end

endmodule
